// File: rtl/sum_diff_decoder_pkg.sv
// Shared constants and helpers for the sum/difference decoder datapath.
// Latency: n/a (package: parameters and constant functions only).
// Backpressure: n/a.
package sum_diff_decoder_pkg;

  localparam int FFT_WIDTH  = 32;
  localparam int FFT_POINTS = 16;

  // Largest signed value of a width-bit word, held in the low width bits (width <= 64).
  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative signed value of a width-bit word, held in the low width bits.
  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // A (WIDTH+1)-bit result fits in WIDTH bits only when its top two bits agree.
  // When they differ, the top bit gives the true sign: 0 = positive overflow.
  function automatic logic ext_ovf(input logic ext_top, input logic ext_msb);
    return ext_top ^ ext_msb;
  endfunction

endpackage

// File: rtl/sum_diff_decoder_sat.sv
// Narrows a (WIDTH+1)-bit signed result to WIDTH bits, either clamping or wrapping, and flags overflow.
// Latency: combinational, 0 cycles.
// Backpressure: none; this block is pure logic.
module sat_round_width
  import sum_diff_decoder_pkg::*;
#(
  parameter int WIDTH    = FFT_WIDTH,
  parameter bit SATURATE = 1'b1
) (
  input  logic [WIDTH:0]   ext,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  localparam logic [63:0]      MAX64 = sat_max(WIDTH);
  localparam logic [63:0]      MIN64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] MAX_V = MAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_V = MIN64[WIDTH-1:0];

  // Detect overflow; clamp toward the true sign, or keep the low WIDTH bits when wrapping.
  always_comb begin
    ovf = ext_ovf(ext[WIDTH], ext[WIDTH-1]);
    res = ext[WIDTH-1:0];
    if (ovf && SATURATE) begin
      res = ext[WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/sum_diff_decoder.sv
// Rebuilds a=s+d, b=s-d from halved sum/difference pairs, with overflow flags and frame-end tagging.
// Latency: 2 cycles from an input transfer to m_valid; 1 pair per cycle sustained.
// Backpressure: s_ready = ~v1 | ~m_valid | m_ready (combinational from m_ready, no skid buffer).
module sum_diff_decoder
  import sum_diff_decoder_pkg::*;
#(
  parameter int WIDTH     = FFT_WIDTH,
  parameter int FRAME_LEN = FFT_POINTS,
  parameter bit SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_sum,
  input  logic [WIDTH-1:0] s_diff,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_a,
  output logic [WIDTH-1:0] m_b,
  output logic             m_last,
  output logic             m_ovf,
  output logic             ovf_sticky,
  input  logic             clr_ovf
);

  localparam int            CW       = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

  // Stage 1: widened sum/difference, not yet narrowed.
  logic             v1_q, v1_d;
  logic [WIDTH:0]   sum1_q, sum1_d;
  logic [WIDTH:0]   diff1_q, diff1_d;
  logic             last1_q, last1_d;
  logic [CW-1:0]    frame_cnt_q, frame_cnt_d;

  // Stage 2: the output register.
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_a_q, m_a_d;
  logic [WIDTH-1:0] m_b_q, m_b_d;
  logic             m_last_q, m_last_d;
  logic             m_ovf_q, m_ovf_d;
  logic             ovf_sticky_q, ovf_sticky_d;

  logic             in_xfer, out_xfer, adv2;
  logic [WIDTH-1:0] sat_a, sat_b;
  logic             ovf_a, ovf_b;

  sat_round_width #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_sat_a (
    .ext (sum1_q),
    .res (sat_a),
    .ovf (ovf_a)
  );

  sat_round_width #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_sat_b (
    .ext (diff1_q),
    .res (sat_b),
    .ovf (ovf_b)
  );

  // Handshakes, stage advance and next-state for both stages, the frame counter and the sticky flag.
  always_comb begin
    s_ready      = ~v1_q | ~m_valid_q | m_ready;
    in_xfer      = s_valid & s_ready;
    out_xfer     = m_valid_q & m_ready;
    adv2         = v1_q & (~m_valid_q | m_ready);

    v1_d         = v1_q;
    sum1_d       = sum1_q;
    diff1_d      = diff1_q;
    last1_d      = last1_q;
    frame_cnt_d  = frame_cnt_q;
    m_valid_d    = m_valid_q;
    m_a_d        = m_a_q;
    m_b_d        = m_b_q;
    m_last_d     = m_last_q;
    m_ovf_d      = m_ovf_q;

    if (in_xfer) begin
      v1_d        = 1'b1;
      sum1_d      = {s_sum[WIDTH-1], s_sum} + {s_diff[WIDTH-1], s_diff};
      diff1_d     = {s_sum[WIDTH-1], s_sum} - {s_diff[WIDTH-1], s_diff};
      last1_d     = (frame_cnt_q == CNT_LAST);
      frame_cnt_d = (frame_cnt_q == CNT_LAST) ? '0 : frame_cnt_q + 1'b1;
    end else if (adv2) begin
      v1_d        = 1'b0;
    end

    if (adv2) begin
      m_valid_d = 1'b1;
      m_a_d     = sat_a;
      m_b_d     = sat_b;
      m_last_d  = last1_q;
      m_ovf_d   = ovf_a | ovf_b;
    end else if (out_xfer) begin
      m_valid_d = 1'b0;
    end

    // A new overflow leaving the block outranks a clear in the same cycle.
    ovf_sticky_d = (ovf_sticky_q & ~clr_ovf) | (out_xfer & m_ovf_q);
  end

  // Pipeline state; reset empties both stages and restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      sum1_q       <= '0;
      diff1_q      <= '0;
      last1_q      <= 1'b0;
      frame_cnt_q  <= '0;
      m_valid_q    <= 1'b0;
      m_a_q        <= '0;
      m_b_q        <= '0;
      m_last_q     <= 1'b0;
      m_ovf_q      <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      sum1_q       <= sum1_d;
      diff1_q      <= diff1_d;
      last1_q      <= last1_d;
      frame_cnt_q  <= frame_cnt_d;
      m_valid_q    <= m_valid_d;
      m_a_q        <= m_a_d;
      m_b_q        <= m_b_d;
      m_last_q     <= m_last_d;
      m_ovf_q      <= m_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_a        = m_a_q;
  assign m_b        = m_b_q;
  assign m_last     = m_last_q;
  assign m_ovf      = m_ovf_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_sum_diff_decoder.sv
// Directed and randomized bench for sum_diff_decoder with a scoreboard of expected output pairs.
// Latency: expects results 2 cycles after an accepted input when downstream is ready.
// Backpressure: drives m_ready patterns and checks s_ready against the bench's own occupancy count.
module tb_sum_diff_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [31:0] s_sum, s_diff;
  logic        m_valid, m_ready;
  logic [31:0] m_a, m_b;
  logic        m_last, m_ovf, ovf_sticky, clr_ovf;

  sum_diff_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sum      (s_sum),
    .s_diff     (s_diff),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_a        (m_a),
    .m_b        (m_b),
    .m_last     (m_last),
    .m_ovf      (m_ovf),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          n_last = 0;
  int          frame_pos = 0;
  bit          last_acc = 0;
  bit          exp_sticky = 0;
  bit          hold_vld = 0;
  logic [65:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Saturating reference: exact 64-bit arithmetic, then clamp to 32-bit signed.
  function automatic void model(input logic [31:0] s, input logic [31:0] d, input bit minus,
                                output logic [31:0] r, output logic o);
    longint x;
    x = minus ? (longint'($signed(s)) - longint'($signed(d)))
              : (longint'($signed(s)) + longint'($signed(d)));
    o = 1'b0;
    r = x[31:0];
    if (x > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF;
      o = 1'b1;
    end else if (x < -64'sd2147483648) begin
      r = 32'h8000_0000;
      o = 1'b1;
    end
  endfunction

  // One clock: sample at negedge, score handshakes, then advance to just after the posedge.
  task automatic tick();
    exp_t e;
    logic oa, ob;
    bit   nxt_sticky;
    @(negedge clk);
    chk("s_ready", s_ready, !(q.size() == 2 && !m_ready));
    chk("sticky", ovf_sticky, exp_sticky);
    if (hold_vld && m_valid) chk("stall_stable", {m_a, m_b, m_last, m_ovf}, held);
    nxt_sticky = exp_sticky & ~clr_ovf;
    if (m_valid && m_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("m_a", m_a, e.a);
        chk("m_b", m_b, e.b);
        chk("m_last", m_last, e.last);
        chk("m_ovf", m_ovf, e.ovf);
        if (e.ovf) nxt_sticky = 1'b1;
        n_out++;
        if (e.last) n_last++;
      end
    end
    hold_vld = m_valid && !m_ready;
    held     = {m_a, m_b, m_last, m_ovf};
    last_acc = s_valid && s_ready;
    if (last_acc) begin
      model(s_sum, s_diff, 1'b0, e.a, oa);
      model(s_sum, s_diff, 1'b1, e.b, ob);
      e.ovf  = oa | ob;
      e.last = (frame_pos == 15);
      frame_pos = (frame_pos + 1) % 16;
      q.push_back(e);
      n_in++;
    end
    @(posedge clk);
    #1;
    exp_sticky = nxt_sticky;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] d);
    s_valid = 1'b1;
    s_sum   = s;
    s_diff  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int start, lasts0, cyc;
    rst_n = 1'b0; s_valid = 1'b0; s_sum = '0; s_diff = '0; m_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_outs", {m_a, m_b, m_last, m_ovf, ovf_sticky}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 1);

    // Single beat 5,2 and its 2-cycle latency.
    m_ready = 1'b1;
    send(32'd5, 32'd2);
    chk("lat_mv_c1", m_valid, 0);
    tick();
    chk("lat_mv_c2", m_valid, 1);
    chk("beat1_a", m_a, 32'd7);
    chk("beat1_b", m_b, 32'd3);
    drain();

    // Mixed signs.
    send(32'hFFFF_FFFD, 32'd4);
    tick();
    chk("beat2_a", m_a, 32'd1);
    chk("beat2_b", m_b, 32'hFFFF_FFF9);
    chk("beat2_ovf", m_ovf, 0);
    drain();

    // Positive overflow, sticky set, then clear.
    send(32'h7FFF_FFFF, 32'd1);
    tick();
    chk("sat_a", m_a, 32'h7FFF_FFFF);
    chk("sat_b", m_b, 32'h7FFF_FFFE);
    chk("sat_ovf", m_ovf, 1);
    drain();
    chk("sticky_set", ovf_sticky, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("sticky_clr", ovf_sticky, 0);

    // Clear coinciding with an overflowing output transfer: set wins.
    m_ready = 1'b0;
    send(32'h8000_0000, 32'd1);
    tick();
    chk("stall_mv", m_valid, 1);
    clr_ovf = 1'b1;
    m_ready = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("sticky_set_wins", ovf_sticky, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;

    // 32 back-to-back beats: exactly two frame ends, no bubbles after fill.
    start  = n_out;
    lasts0 = n_last;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_sum  = 32'(i * 3);
      s_diff = 32'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    chk("b2b_no_bubble", n_out - start, 32);
    chk("b2b_lasts", n_last - lasts0, 2);

    // Random valid/ready over 1000 accepted beats.
    start = n_in;
    cyc   = 0;
    last_acc = 1'b1;
    while (n_in - start < 1000 && cyc < 10000) begin
      if (!s_valid || last_acc) begin
        s_valid = 1'($urandom_range(0, 1));
        s_sum   = $urandom();
        s_diff  = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 1000));
      end
      m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("rand_count", (n_in - start) >= 1000, 1);
    drain();

    // Reset in mid-frame with two pairs in flight.
    for (int i = 0; i < 7; i++) send(32'(i), 32'd1);
    drain();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_sum = 32'd100; s_diff = 32'd1;
    tick();
    s_sum = 32'd200;
    tick();
    s_valid = 1'b0;
    chk("inflight2", q.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_outs", {m_a, m_b, m_last, m_ovf, ovf_sticky}, 0);
    q.delete();
    frame_pos  = 0;
    exp_sticky = 1'b0;
    hold_vld   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    lasts0 = n_last;
    m_ready = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      s_sum = 32'(i); s_diff = 32'd2;
      tick();
    end
    s_valid = 1'b0;
    drain();
    chk("post_rst_no_last15", n_last - lasts0, 0);
    send(32'd9, 32'd9);
    drain();
    chk("post_rst_last16", n_last - lasts0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
